wb_result_stage: RTL and testbench

Registered writeback stage for the pipelined RV32I core. It replaces the purely combinational result select with a generalised, parametrised version.
- Latches the MEM/WB bundle and selects among NSRC result sources.
- Waits on a data-memory read handshake for loads, then aligns and sign/zero-extends the load data.
- Produces the register-file write (valid, rd, we, data) one cycle later.
- Stalls the upstream pipeline while a load is outstanding.

---
 rtl/wb_result_stage.sv | 192 +++++++++++++++++++
 tb/tb_wb_result_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_stage.sv
// wb_result_stage: registered RV32I/RV64I writeback stage with result-source select,
// load handshake, load alignment/extension and upstream stall.
`default_nettype none

module wb_result_stage #(
  parameter int XLEN  = 32,
  parameter int NSRC  = 4,
  parameter int SRC_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_alu_result,
  input  logic [(NSRC-2)*XLEN-1:0]   in_ext,
  input  logic [SRC_W-1:0]           in_result_src,
  input  logic [2:0]                 in_funct3,
  input  logic [4:0]                 in_rd,
  input  logic                       in_reg_write,
  input  logic                       flush,
  input  logic                       mem_rvalid,
  input  logic [XLEN-1:0]            mem_rdata,
  output logic                       wb_valid,
  output logic                       wb_we,
  output logic [4:0]                 wb_rd,
  output logic [XLEN-1:0]            wb_result,
  output logic                       wb_misalign,
  output logic                       stall_req
);

  localparam int OFF_W = (XLEN == 64) ? 3 : 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   cap_alu_q, cap_alu_d;
  logic [2:0]        cap_f3_q, cap_f3_d;
  logic [4:0]        cap_rd_q, cap_rd_d;
  logic              cap_rw_q, cap_rw_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_result_q, wb_result_d;
  logic              wb_misalign_q, wb_misalign_d;

  logic [XLEN-1:0]   src_data;
  logic [OFF_W-1:0]  ld_off;
  logic [XLEN-1:0]   ld_shifted;
  logic [XLEN-1:0]   ld_mask;
  logic [XLEN-1:0]   ld_data;
  logic [1:0]        ld_size;
  logic              ld_signed;
  logic              ld_sbit;
  logic              ld_misalign;

  // Out-of-range source indices fall back to the ALU result.
  always_comb begin
    src_data = in_alu_result;
    for (int i = 2; i < NSRC; i++) begin
      if (in_result_src == SRC_W'(i)) begin
        src_data = in_ext[(i-2)*XLEN +: XLEN];
      end
    end
  end

  // Size codes: 0=byte, 1=half, 2=word, 3=double; unknown encodings act as LW.
  always_comb begin
    ld_size   = 2'd2;
    ld_signed = 1'b1;
    unique case (cap_f3_q)
      3'b000: begin ld_size = 2'd0; ld_signed = 1'b1; end
      3'b100: begin ld_size = 2'd0; ld_signed = 1'b0; end
      3'b001: begin ld_size = 2'd1; ld_signed = 1'b1; end
      3'b101: begin ld_size = 2'd1; ld_signed = 1'b0; end
      3'b110: if (XLEN == 64) begin ld_size = 2'd2; ld_signed = 1'b0; end
      3'b011: if (XLEN == 64) begin ld_size = 2'd3; ld_signed = 1'b0; end
      default: begin ld_size = 2'd2; ld_signed = 1'b1; end
    endcase
  end

  always_comb begin
    ld_off     = cap_alu_q[OFF_W-1:0];
    ld_shifted = mem_rdata >> {ld_off, 3'b000};
    ld_mask    = '1;
    ld_sbit    = 1'b0;
    case (ld_size)
      2'd0:    begin ld_mask = XLEN'(8'hFF);          ld_sbit = ld_shifted[7];  end
      2'd1:    begin ld_mask = XLEN'(16'hFFFF);       ld_sbit = ld_shifted[15]; end
      2'd2:    begin ld_mask = XLEN'(32'hFFFF_FFFF);  ld_sbit = ld_shifted[31]; end
      default: begin ld_mask = '1;                    ld_sbit = 1'b0;           end
    endcase
    ld_data = (ld_shifted & ld_mask) | ((ld_signed && ld_sbit) ? ~ld_mask : '0);

    case (ld_size)
      2'd1:    ld_misalign = ld_off[0];
      2'd2:    ld_misalign = (ld_off[1:0] != 2'b00);
      2'd3:    ld_misalign = (ld_off != '0);
      default: ld_misalign = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cap_alu_d     = cap_alu_q;
    cap_f3_d      = cap_f3_q;
    cap_rd_d      = cap_rd_q;
    cap_rw_d      = cap_rw_q;
    wb_valid_d    = 1'b0;
    wb_we_d       = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_result_d   = wb_result_q;
    wb_misalign_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          if (in_result_src == SRC_W'(1)) begin
            cap_alu_d = in_alu_result;
            cap_f3_d  = in_funct3;
            cap_rd_d  = in_rd;
            cap_rw_d  = in_reg_write;
            state_d   = S_WAIT;
          end else begin
            wb_valid_d  = 1'b1;
            wb_we_d     = in_reg_write && (in_rd != 5'd0);
            wb_rd_d     = in_rd;
            wb_result_d = src_data;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = mem_rvalid ? S_IDLE : S_DRAIN;
        end else if (mem_rvalid) begin
          state_d       = S_IDLE;
          wb_valid_d    = 1'b1;
          wb_misalign_d = ld_misalign;
          wb_we_d       = cap_rw_q && (cap_rd_q != 5'd0) && !ld_misalign;
          wb_rd_d       = cap_rd_q;
          wb_result_d   = ld_data;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cap_alu_q     <= '0;
      cap_f3_q      <= '0;
      cap_rd_q      <= '0;
      cap_rw_q      <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_result_q   <= '0;
      wb_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cap_alu_q     <= cap_alu_d;
      cap_f3_q      <= cap_f3_d;
      cap_rd_q      <= cap_rd_d;
      cap_rw_q      <= cap_rw_d;
      wb_valid_q    <= wb_valid_d;
      wb_we_q       <= wb_we_d;
      wb_rd_q       <= wb_rd_d;
      wb_result_q   <= wb_result_d;
      wb_misalign_q <= wb_misalign_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign stall_req   = ~in_ready;
  assign wb_valid    = wb_valid_q;
  assign wb_we       = wb_we_q;
  assign wb_rd       = wb_rd_q;
  assign wb_result   = wb_result_q;
  assign wb_misalign = wb_misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_result_stage.sv
// tb_wb_result_stage: directed checks of wb_result_stage in 32-bit and 64-bit builds
// sharing one control stream.
`default_nettype none

module tb_wb_result_stage;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [1:0]    in_result_src;
  logic [2:0]    in_funct3;
  logic [4:0]    in_rd;
  logic          in_reg_write;
  logic          flush;
  logic          mem_rvalid;

  logic [31:0]   alu_a;
  logic [63:0]   ext_a;
  logic [31:0]   rdata_a;
  logic          in_ready_a, wb_valid_a, wb_we_a, wb_misalign_a, stall_req_a;
  logic [4:0]    wb_rd_a;
  logic [31:0]   wb_result_a;

  logic [63:0]   alu_b;
  logic [127:0]  ext_b;
  logic [63:0]   rdata_b;
  logic          in_ready_b, wb_valid_b, wb_we_b, wb_misalign_b, stall_req_b;
  logic [4:0]    wb_rd_b;
  logic [63:0]   wb_result_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_result_stage #(.XLEN(32), .NSRC(4), .SRC_W(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_alu_result(alu_a), .in_ext(ext_a), .in_result_src(in_result_src),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .flush(flush), .mem_rvalid(mem_rvalid), .mem_rdata(rdata_a),
    .wb_valid(wb_valid_a), .wb_we(wb_we_a), .wb_rd(wb_rd_a),
    .wb_result(wb_result_a), .wb_misalign(wb_misalign_a), .stall_req(stall_req_a)
  );

  wb_result_stage #(.XLEN(64), .NSRC(4), .SRC_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_alu_result(alu_b), .in_ext(ext_b), .in_result_src(in_result_src),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .flush(flush), .mem_rvalid(mem_rvalid), .mem_rdata(rdata_b),
    .wb_valid(wb_valid_b), .wb_we(wb_we_b), .wb_rd(wb_rd_b),
    .wb_result(wb_result_b), .wb_misalign(wb_misalign_b), .stall_req(stall_req_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues a load, holds mem_rvalid low for `gap` cycles after capture, then pulses it.
  // Returns just after the edge that produces the writeback.
  task automatic do_load(input logic [2:0] f3, input logic [63:0] addr, input logic [4:0] rd,
                         input logic [63:0] rdata, input int gap);
    in_valid = 1'b1; in_result_src = 2'd1; in_funct3 = f3;
    alu_a = addr[31:0]; alu_b = addr; in_rd = rd; in_reg_write = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      chk("load_stall_ready", {63'd0, in_ready_a}, 64'd0);
      tick();
    end
    chk("load_stall_req", {63'd0, stall_req_a}, 64'd1);
    mem_rvalid = 1'b1; rdata_a = rdata[31:0]; rdata_b = rdata;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result_src = '0; in_funct3 = '0; in_rd = '0;
    in_reg_write = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
    alu_a = '0; ext_a = '0; rdata_a = '0; alu_b = '0; ext_b = '0; rdata_b = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_wb_valid", {63'd0, wb_valid_a}, 64'd0);
    chk("rst_wb_result", {32'd0, wb_result_a}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    chk("rst_stall_req", {63'd0, stall_req_a}, 64'd0);

    // ALU op
    in_valid = 1'b1; in_result_src = 2'd0; alu_a = 32'h0000_1234; in_rd = 5'd5; in_reg_write = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("alu_valid", {63'd0, wb_valid_a}, 64'd1);
    chk("alu_we", {63'd0, wb_we_a}, 64'd1);
    chk("alu_rd", {59'd0, wb_rd_a}, 64'd5);
    chk("alu_result", {32'd0, wb_result_a}, 64'h1234);
    tick();
    chk("alu_pulse_end", {63'd0, wb_valid_a}, 64'd0);
    chk("alu_result_hold", {32'd0, wb_result_a}, 64'h1234);

    // mem_rvalid in IDLE is ignored
    mem_rvalid = 1'b1; rdata_a = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_no_wb", {63'd0, wb_valid_a}, 64'd0);
    chk("idle_rvalid_ready", {63'd0, in_ready_a}, 64'd1);

    // LB / LBU at byte 3
    do_load(3'b000, 64'h3, 5'd6, 64'h8000_0000, 2);
    chk("lb_valid", {63'd0, wb_valid_a}, 64'd1);
    chk("lb_result", {32'd0, wb_result_a}, 64'hFFFF_FF80);
    chk("lb_rd", {59'd0, wb_rd_a}, 64'd6);
    chk("lb_ready_back", {63'd0, in_ready_a}, 64'd1);
    do_load(3'b100, 64'h3, 5'd6, 64'h8000_0000, 2);
    chk("lbu_result", {32'd0, wb_result_a}, 64'h0000_0080);

    // Halfword loads
    do_load(3'b101, 64'h2, 5'd8, 64'hBEEF_0000, 0);
    chk("lhu_result", {32'd0, wb_result_a}, 64'h0000_BEEF);
    chk("lhu_we", {63'd0, wb_we_a}, 64'd1);
    do_load(3'b001, 64'h2, 5'd8, 64'h8001_0000, 1);
    chk("lh_result", {32'd0, wb_result_a}, 64'hFFFF_8001);

    // Misaligned LW
    do_load(3'b010, 64'h1, 5'd9, 64'h1111_2222, 1);
    chk("lw_mis_valid", {63'd0, wb_valid_a}, 64'd1);
    chk("lw_mis_flag", {63'd0, wb_misalign_a}, 64'd1);
    chk("lw_mis_we", {63'd0, wb_we_a}, 64'd0);
    tick();
    chk("lw_mis_pulse_end", {63'd0, wb_misalign_a}, 64'd0);

    // Flush during WAIT, data arrives two cycles later
    in_valid = 1'b1; in_result_src = 2'd1; in_funct3 = 3'b010; alu_a = 32'h0; in_rd = 5'd7;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_ready", {63'd0, in_ready_a}, 64'd0);
    tick();
    chk("drain_still", {63'd0, stall_req_a}, 64'd1);
    mem_rvalid = 1'b1; rdata_a = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    chk("drain_no_wb", {63'd0, wb_valid_a}, 64'd0);
    chk("drain_ready_back", {63'd0, in_ready_a}, 64'd1);

    // Flush coinciding with mem_rvalid
    in_valid = 1'b1; in_result_src = 2'd1; in_funct3 = 3'b010; in_rd = 5'd7;
    tick();
    in_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1;
    tick();
    flush = 1'b0; mem_rvalid = 1'b0;
    chk("flush_rv_no_wb", {63'd0, wb_valid_a}, 64'd0);
    chk("flush_rv_ready", {63'd0, in_ready_a}, 64'd1);

    // Flush in IDLE drops the bundle
    in_valid = 1'b1; in_result_src = 2'd0; alu_a = 32'h99; in_rd = 5'd3; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_no_wb", {63'd0, wb_valid_a}, 64'd0);

    // Back-to-back PC+4, immediate, rd=0
    ext_a = {32'h1234_5000, 32'h0000_0104};
    in_valid = 1'b1; in_result_src = 2'd2; in_rd = 5'd1; in_reg_write = 1'b1;
    tick();
    in_result_src = 2'd3; in_rd = 5'd2;
    chk("b2b_pc4_valid", {63'd0, wb_valid_a}, 64'd1);
    chk("b2b_pc4_result", {32'd0, wb_result_a}, 64'h104);
    tick();
    in_result_src = 2'd0; alu_a = 32'h7; in_rd = 5'd0;
    chk("b2b_imm_valid", {63'd0, wb_valid_a}, 64'd1);
    chk("b2b_imm_result", {32'd0, wb_result_a}, 64'h1234_5000);
    tick();
    in_valid = 1'b0;
    chk("b2b_x0_valid", {63'd0, wb_valid_a}, 64'd1);
    chk("b2b_x0_result", {32'd0, wb_result_a}, 64'h7);
    chk("b2b_x0_we", {63'd0, wb_we_a}, 64'd0);

    // Reset in the middle of WAIT
    in_valid = 1'b1; in_result_src = 2'd1; in_funct3 = 3'b000; in_rd = 5'd4;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wait_ready", {63'd0, in_ready_a}, 64'd1);
    chk("rst_wait_result", {32'd0, wb_result_a}, 64'd0);

    // 64-bit build
    do_load(3'b110, 64'h0, 5'd10, 64'h0000_0000_FFFF_FFFF, 1);
    chk("x64_lwu_valid", {63'd0, wb_valid_b}, 64'd1);
    chk("x64_lwu_result", wb_result_b, 64'h0000_0000_FFFF_FFFF);
    do_load(3'b010, 64'h4, 5'd10, 64'h8000_0000_0000_0000, 1);
    chk("x64_lw_result", wb_result_b, 64'hFFFF_FFFF_8000_0000);
    do_load(3'b011, 64'h0, 5'd11, 64'h0123_4567_89AB_CDEF, 0);
    chk("x64_ld_result", wb_result_b, 64'h0123_4567_89AB_CDEF);
    chk("x64_ld_we", {63'd0, wb_we_b}, 64'd1);
    do_load(3'b011, 64'h4, 5'd11, 64'h0123_4567_89AB_CDEF, 0);
    chk("x64_ld_mis_flag", {63'd0, wb_misalign_b}, 64'd1);
    chk("x64_ld_mis_we", {63'd0, wb_we_b}, 64'd0);
    chk("x64_ready_back", {63'd0, stall_req_b}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
